// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the board UART (receiver and transmitter).
//   UART_DATA_BITS  - payload bits per frame
//   uart_state_t    - receiver state encoding
//   uart_half_bit() - clock count to the middle of a bit cell
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  // Offset from a bit's leading edge to its centre, in system clocks.
  function automatic int uart_half_bit(input int cpb);
    return (cpb - 1) / 2;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchronizer for a single asynchronous input.
//   clk - destination clock
//   rst - synchronous active-high reset, loads RST_VAL into every stage
//   d   - asynchronous input
//   q   - synchronized output, DEPTH cycles behind d
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= {DEPTH{RST_VAL}};
    else     chain <= {chain[DEPTH-2:0], d};
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, single sample at the bit centre.
//   clk        - system clock
//   rst        - synchronous active-high reset
//   rxd        - asynchronous serial input, idles high
//   data       - last good byte (LSB first on the wire), held until replaced
//   data_valid - one-cycle pulse when data is updated
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   busy       - high from confirmed start until back in idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 86,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int             CW     = $clog2(CLOCKS_PER_BIT);
  localparam int             BW     = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0]  HALF_C = CW'(uart_half_bit(CLOCKS_PER_BIT));
  localparam logic [CW-1:0]  LAST_C = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0]  LAST_B = BW'(UART_DATA_BITS - 1);

  logic                      rxd_s;
  uart_state_t               state;
  logic [CW-1:0]             cnt;
  logic [BW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      cnt        <= cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          // Counter held at zero so START begins its half-bit count at 0.
          busy <= 1'b0;
          cnt  <= '0;
          if (!rxd_s) state <= ST_START;
        end
        ST_START: begin
          // busy rises one cycle into START, after the edge is seen twice.
          busy <= 1'b1;
          if (cnt == HALF_C) begin
            cnt <= '0;
            if (rxd_s) begin
              state <= ST_IDLE;       // glitch: line back high at bit centre
              busy  <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end
        end
        ST_DATA: begin
          busy <= 1'b1;
          if (cnt == LAST_C) begin
            cnt     <= '0;
            shreg   <= {rxd_s, shreg[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_B) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt == LAST_C) begin
            cnt <= '0;
            if (rxd_s) begin
              data       <= shreg;
              data_valid <= 1'b1;
              state      <= ST_IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          // Line held low: wait it out silently.
          cnt <= '0;
          if (rxd_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into three receivers (8, 4 and 86 clocks/bit).
// The bench predicts each pulse (time, kind, byte) from the frame it sends
// and the end-to-end latency formula; a per-cycle compare process matches
// the DUT pulses and held data against those predictions.
module tb_uart_rx;

  localparam int NI   = 3;
  localparam int SYNC = 2;

  function automatic int cpb_of(input int i);
    case (i)
      0:       return 8;
      1:       return 4;
      default: return 86;
    endcase
  endfunction

  function automatic int lat_of(input int i);
    return SYNC + 1 + (cpb_of(i) - 1) / 2 + 9 * cpb_of(i) + 1;
  endfunction

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [NI];
  logic       rxd  [NI];
  logic [7:0] dout [NI];
  logic       dv   [NI];
  logic       fe   [NI];
  logic       busy [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_rx #(.CLOCKS_PER_BIT(cpb_of(g)), .SYNC_STAGES(SYNC)) dut (
      .clk        (clk),
      .rst        (rst[g]),
      .rxd        (rxd[g]),
      .data       (dout[g]),
      .data_valid (dv[g]),
      .frame_err  (fe[g]),
      .busy       (busy[g])
    );
  end

  typedef struct {
    int         inst;
    int         t;
    bit         err;
    logic [7:0] b;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] mdl_data [NI];
  bit         prev_p   [NI];
  int         dv_cyc   [NI];
  int         dv0_hist[$];
  logic       rst_d    [NI];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) rst_d[i] <= rst[i];
  end

  function automatic void chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic check_inst(input int i);
    int  idx;
    int  d;
    bit  pulse;
    if (rst_d[i] === 1'b1) begin
      mdl_data[i] = 8'h00;
      for (int k = q.size() - 1; k >= 0; k--) if (q[k].inst == i) q.delete(k);
    end
    pulse = (dv[i] === 1'b1) || (fe[i] === 1'b1);
    chk(!(dv[i] === 1'b1 && fe[i] === 1'b1), "exclusive", i, 0);
    if (pulse) chk(!prev_p[i], "consecutive", i, 0);
    prev_p[i] = pulse;
    if (dv[i] !== 1'b1) chk(dout[i] === mdl_data[i], "data_hold", dout[i], mdl_data[i]);
    if (pulse) begin
      idx = -1;
      for (int k = 0; k < q.size(); k++) if (idx < 0 && q[k].inst == i) idx = k;
      if (idx < 0) begin
        chk(1'b0, "unexpected_pulse", i, -1);
      end else begin
        d = cyc - q[idx].t;
        chk(d >= -1 && d <= 1, "pulse_time", cyc, q[idx].t);
        chk((fe[i] === 1'b1) == q[idx].err, "pulse_kind", int'(fe[i]), int'(q[idx].err));
        if (dv[i] === 1'b1) begin
          chk(dout[i] === q[idx].b, "byte", dout[i], q[idx].b);
          mdl_data[i] = q[idx].b;
          dv_cyc[i]   = cyc;
          if (i == 0) dv0_hist.push_back(cyc);
        end
        q.delete(idx);
      end
    end
    for (int k = q.size() - 1; k >= 0; k--)
      if (q[k].inst == i && cyc > q[k].t + 1) begin
        chk(1'b0, "missing_pulse", cyc, q[k].t);
        q.delete(k);
      end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      mdl_data[i] = 8'h00;
      prev_p[i]   = 1'b0;
      dv_cyc[i]   = -100000;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) check_inst(i);
    end
  end

  task automatic drive_bit(input int i, input logic v);
    rxd[i] = v;
    repeat (cpb_of(i)) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int i, input int n);
    rxd[i] = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] b, input bit stop,
                      input int abort_bit, input bit expect_p, output int t0);
    t0 = cyc;
    if (expect_p) q.push_back('{i, t0 + lat_of(i), !stop, b});
    drive_bit(i, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == abort_bit) begin
        rxd[i] = b[k];
        rst[i] = 1'b1;
        @(posedge clk); #1;
        rst[i] = 1'b0;
        repeat (cpb_of(i) - 1) @(posedge clk);
        #1;
      end else begin
        drive_bit(i, b[k]);
      end
    end
    drive_bit(i, stop);
  endtask

  initial begin
    int t0;
    int n;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1;
      rxd[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    chk(dout[0] === 8'h00, "reset_data", dout[0], 0);
    chk(busy[0] === 1'b0, "reset_busy", int'(busy[0]), 0);
    chk(dv[0] === 1'b0 && fe[0] === 1'b0, "reset_pulses", int'(dv[0]), 0);

    // Short low glitch: rejected at the start-bit centre.
    rxd[0] = 1'b0;
    repeat (2) @(posedge clk); #1;
    rxd[0] = 1'b1;
    repeat (7) @(posedge clk); #1;
    chk(busy[0] === 1'b0, "glitch_busy", int'(busy[0]), 0);
    chk(dout[0] === 8'h00, "glitch_data", dout[0], 0);
    idle(0, 16);

    // Single 0x55 frame.
    send(0, 8'h55, 1'b1, -1, 1'b1, t0);
    idle(0, 16);
    chk(dout[0] === 8'h55, "frame55_data", dout[0], 8'h55);
    chk(busy[0] === 1'b0, "frame55_busy", int'(busy[0]), 0);
    chk(dv_cyc[0] - t0 >= 78 && dv_cyc[0] - t0 <= 80, "lat_cpb8", dv_cyc[0] - t0, 79);

    // Back-to-back 0xA5, 0x3C.
    send(0, 8'hA5, 1'b1, -1, 1'b1, t0);
    send(0, 8'h3C, 1'b1, -1, 1'b1, t0);
    idle(0, 16);
    n = dv0_hist.size();
    if (n >= 2) chk(dv0_hist[n-1] - dv0_hist[n-2] == 80, "b2b_spacing", dv0_hist[n-1] - dv0_hist[n-2], 80);
    else        chk(1'b0, "b2b_count", n, 3);
    chk(dout[0] === 8'h3C, "b2b_data", dout[0], 8'h3C);

    // Stop bit low, then held low: framing error and break.
    send(0, 8'h81, 1'b0, -1, 1'b1, t0);
    repeat (40) @(posedge clk); #1;
    chk(busy[0] === 1'b1, "break_busy", int'(busy[0]), 1);
    rxd[0] = 1'b1;
    repeat (SYNC + 3) @(posedge clk); #1;
    chk(busy[0] === 1'b0, "break_release", int'(busy[0]), 0);
    chk(dout[0] === 8'h3C, "ferr_data_kept", dout[0], 8'h3C);
    idle(0, 16);

    // Reset during bit 4 of 0xFF, then 0x12.
    send(0, 8'hFF, 1'b1, 4, 1'b0, t0);
    idle(0, 16);
    chk(dout[0] === 8'h00, "abort_data", dout[0], 0);
    send(0, 8'h12, 1'b1, -1, 1'b1, t0);
    idle(0, 16);
    chk(dout[0] === 8'h12, "after_abort_data", dout[0], 8'h12);

    // 4 clocks per bit.
    send(1, 8'h00, 1'b1, -1, 1'b1, t0);
    idle(1, 12);
    chk(dv_cyc[1] - t0 >= 40 && dv_cyc[1] - t0 <= 42, "lat_cpb4_00", dv_cyc[1] - t0, 41);
    send(1, 8'hFF, 1'b1, -1, 1'b1, t0);
    idle(1, 12);
    chk(dout[1] === 8'hFF, "cpb4_ff", dout[1], 8'hFF);
    chk(dv_cyc[1] - t0 >= 40 && dv_cyc[1] - t0 <= 42, "lat_cpb4_ff", dv_cyc[1] - t0, 41);

    // 86 clocks per bit.
    send(2, 8'h00, 1'b1, -1, 1'b1, t0);
    idle(2, 258);
    chk(dv_cyc[2] - t0 >= 819 && dv_cyc[2] - t0 <= 821, "lat_cpb86_00", dv_cyc[2] - t0, 820);
    send(2, 8'hFF, 1'b1, -1, 1'b1, t0);
    idle(2, 258);
    chk(dout[2] === 8'hFF, "cpb86_ff", dout[2], 8'hFF);
    chk(dv_cyc[2] - t0 >= 819 && dv_cyc[2] - t0 <= 821, "lat_cpb86_ff", dv_cyc[2] - t0, 820);

    repeat (10) @(posedge clk); #1;
    chk(q.size() == 0, "pending_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the FTDI link on `serial_rxd`: it recovers 8N1 bytes at a fixed baud rate and presents each byte on a one-cycle valid strobe. It is the receive half of the board UART, the counterpart to the transmitter that drives `serial_txd`. It sits between the top-level pin and any command or LED-control logic, and is clocked from the single system clock.

## Interface

Parameters:
- `CLOCKS_PER_BIT`, default 86 (10 MHz / 115200): system clocks per serial bit. Legal range is ≥ 4.
- `SYNC_STAGES`, default 2: metastability flops on `rxd`. Legal range is ≥ 2.

Ports:
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `rxd`  in  1: asynchronous serial input; idle level is 1.
- `data`  out  8: last good byte, LSB received first; holds until the next good byte.
- `data_valid`  out  1: one-cycle pulse when `data` is updated.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1: high from confirmed start bit until the receiver returns to IDLE.

## Operation

- `rxd` passes through `SYNC_STAGES` flops, each reset to 1. All decisions use the synchronized `rxd_s`.
- A bit-phase counter of width $clog2(CLOCKS_PER_BIT) is reloaded on every state entry. HALF = (CLOCKS_PER_BIT-1)/2, integer division.
- States:
  - IDLE: `busy`=0. If `rxd_s`=0, go to START with counter=0.
  - START: count to HALF, then sample `rxd_s`. If 0, go to DATA (bit index 0, counter=0). If 1, the start was a glitch: go to IDLE with no pulse.
  - DATA: when the counter reaches CLOCKS_PER_BIT-1, shift `rxd_s` into the shift register MSB and right-shift, so the first bit ends in bit 0. Then increment the bit index and clear the counter. After bit 7, go to STOP.
  - STOP: when the counter reaches CLOCKS_PER_BIT-1, sample `rxd_s`. If 1, load `data` from the shift register, pulse `data_valid`, and go to IDLE. If 0, pulse `frame_err`, leave `data` unchanged, and go to BREAK.
  - BREAK: wait for `rxd_s`=1, then go to IDLE. This covers a held-low line; no further pulses fire while in BREAK.
- `busy` is 1 in START (after the first cycle), DATA, STOP and BREAK.
- `data_valid` and `frame_err` are mutually exclusive and never high for two consecutive cycles.
- A new start bit may be detected in the cycle immediately after the return to IDLE, so back-to-back frames with a single stop bit are received.

## Timing

- Reset values: `data`=8'h00, `data_valid`=0, `frame_err`=0, `busy`=0, state=IDLE, sync flops=1, shift register=0.
- `rst` is honoured in any state. Mid-frame it aborts the frame with no pulse, and the next falling edge is treated as a fresh start.
- Input latency: a falling edge on `rxd` appears on `rxd_s` after `SYNC_STAGES` cycles.
- Sample points, counted from START entry: start bit at cycle HALF, data bit k at HALF+(k+1)·CLOCKS_PER_BIT, stop bit at HALF+9·CLOCKS_PER_BIT. These are registered; the outputs change on the following edge.
- `data_valid` therefore rises `SYNC_STAGES` + 1 + HALF + 9·CLOCKS_PER_BIT + 1 cycles after the `rxd` falling edge. The bench checks this within ±1 cycle.
- Tolerated baud mismatch is about ±4 % at the default setting. No oversampling or majority vote is performed.

## Structure

- Package `uart_pkg` holds:
  - the state encoding (IDLE, START, DATA, STOP, BREAK) as a 3-bit localparam/enum;
  - `UART_DATA_BITS`=8;
  - `uart_half_bit(cpb)` as a constant function, shared with the transmitter.
- Sub-module `sync_ff` (parameterised depth and reset value) holds the input synchronizer. It is reusable for the GPIO inputs.
- The counter, bit index, shift register and FSM stay in `uart_rx`.

## Test plan

All scenarios use `CLOCKS_PER_BIT`=8 unless stated.

1. Reset, then drive the frame for 0x55 with a stop bit: exactly one `data_valid`, `data`=0x55, `frame_err` never high, `busy` returns to 0.
2. Send 0xA5 then 0x3C back-to-back with no idle gap: two `data_valid` pulses 80 cycles apart, carrying 0xA5 then 0x3C in order.
3. Drive `rxd` low for 2 cycles, then high: no pulse, `busy` returns to 0 within HALF+`SYNC_STAGES`+2 cycles, and `data` stays 0x00.
4. Send 0x81 with the stop bit driven 0, hold low 40 cycles, then release: one `frame_err` pulse, no `data_valid`, `data` keeps its previous value, `busy` stays 1 until `rxd_s` returns high.
5. Assert `rst` for 1 cycle during bit 4 of 0xFF, then send 0x12: no pulse for the aborted frame, and `data`=0x12 on the next `data_valid`.
6. With `CLOCKS_PER_BIT`=4, and again at 86, send 0x00 and 0xFF: correct bytes, and latency matches the Timing formula ±1.
